// File: rtl/pwm_capture_if.sv
// Register-bus bundle for pwm_capture: one request per reg_cs cycle,
// single-cycle reg_ack with registered read data.
interface pwm_capture_if;
    logic        reg_cs;
    logic        reg_wr;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    modport master (
        output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        output reg_rdata, reg_ack
    );
endinterface

// File: rtl/pwm_capture.sv
// Single-channel PWM capture: measures high time and period of a selected pad.
// Optional PWM_CAP_GLITCH_FILT_EN adds a 3-sample majority filter (STATUS[7]=1).
module pwm_capture #(
    parameter int unsigned CNT_W = 16
) (
    input  logic         mclk,
    input  logic         h_reset,
    pwm_capture_if.slave bus,
    input  logic [7:0]   pad_gpio,
    output logic         cap_intr
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        MEAS_HIGH  = 2'd2,
        MEAS_LOW   = 2'd3
    } state_t;

`ifdef PWM_CAP_GLITCH_FILT_EN
    localparam logic       FILT_EN = 1'b1;
    localparam logic [2:0] BLANK   = 3'd5;
`else
    localparam logic       FILT_EN = 1'b0;
    localparam logic [2:0] BLANK   = 3'd3;
`endif

    logic [7:0]       cfg_q, cfg_d;
    logic             ack_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             done_q, done_d, ovf_q, ovf_d;
    logic             set_done, set_ovf;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_tmp_q, high_tmp_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [2:0]       blank_q, blank_d;
    logic             raw, sample, rise, fall;
    logic             acc, cfg_wr, st_wr, sel_diff, restart, blank_load;
    logic [1:0]       w1c;
    logic             unused_bus;

    assign unused_bus = ^{bus.reg_wdata[31:8], bus.reg_be[3:1]};

    // Bus decode: a request is accepted only when no ack is outstanding.
    assign acc    = bus.reg_cs & ~ack_q;
    assign cfg_wr = acc & bus.reg_wr & (bus.reg_addr == 2'd0) & bus.reg_be[0];
    assign st_wr  = acc & bus.reg_wr & (bus.reg_addr == 2'd1) & bus.reg_be[0];
    assign cfg_d  = cfg_wr ? bus.reg_wdata[7:0] : cfg_q;
    assign w1c    = st_wr ? bus.reg_wdata[1:0] : 2'b00;

    // Enabling or re-steering the input blanks edges until the synchroniser
    // holds only samples of the new selection.
    assign sel_diff   = (cfg_d[4:1] != cfg_q[4:1]);
    assign restart    = cfg_q[0] & cfg_d[0] & sel_diff;
    assign blank_load = cfg_d[0] & (~cfg_q[0] | sel_diff);
    assign blank_d    = blank_load ? BLANK :
                        (blank_q != 3'd0) ? blank_q - 3'd1 : 3'd0;

`ifdef PWM_CAP_GLITCH_FILT_EN
    logic [2:0] filt_q;
    always_ff @(posedge mclk) begin
        if (h_reset) filt_q <= '0;
        else         filt_q <= {filt_q[1:0], sync2_q};
    end
    assign raw = (filt_q[0] & filt_q[1]) | (filt_q[1] & filt_q[2]) | (filt_q[0] & filt_q[2]);
`else
    assign raw = sync2_q;
`endif

    assign sample = raw ^ cfg_q[4];
    assign rise   = sample & ~prev_q & (blank_q == 3'd0);
    assign fall   = ~sample & prev_q & (blank_q == 3'd0);

    always_ff @(posedge mclk) begin
        if (h_reset) begin
            cfg_q   <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            blank_q <= '0;
        end else begin
            cfg_q   <= cfg_d;
            ack_q   <= acc;
            rdata_q <= rdata_d;
            sync1_q <= pad_gpio[cfg_q[3:1]];
            sync2_q <= sync1_q;
            prev_q  <= sample;
            blank_q <= blank_d;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (acc && !bus.reg_wr) begin
            unique case (bus.reg_addr)
                2'd0: rdata_d = {24'd0, cfg_q};
                2'd1: rdata_d = {24'd0, FILT_EN, 2'b00, 1'b0, state_q, ovf_q, done_q};
                2'd2: rdata_d = {{(32-CNT_W){1'b0}}, period_q};
                2'd3: rdata_d = {{(32-CNT_W){1'b0}}, high_q};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (h_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            high_tmp_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_tmp_q <= high_tmp_d;
            period_q   <= period_d;
            high_q     <= high_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_tmp_d = high_tmp_q;
        period_d   = period_q;
        high_d     = high_q;
        set_done   = 1'b0;
        set_ovf    = 1'b0;
        if (!cfg_q[0]) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (restart) begin
            state_d = WAIT_START;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!done_q) state_d = WAIT_START;
                end
                WAIT_START: begin
                    if (rise) begin
                        state_d = MEAS_HIGH;
                        cnt_d   = CNT_W'(1);
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        high_tmp_d = cnt_q;
                        state_d    = MEAS_LOW;
                        cnt_d      = cnt_q + CNT_W'(1);
                    end else if (cnt_q == '1) begin
                        set_ovf = 1'b1;
                        state_d = WAIT_START;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = high_tmp_q;
                        set_done = 1'b1;
                        cnt_d    = CNT_W'(1);
                        state_d  = cfg_q[7] ? IDLE : MEAS_HIGH;
                    end else if (cnt_q == '1) begin
                        set_ovf = 1'b1;
                        state_d = WAIT_START;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // A set in the same cycle as a write-1-to-clear wins.
        done_d = set_done | (done_q & ~w1c[0]);
        ovf_d  = set_ovf  | (ovf_q  & ~w1c[1]);
    end

    assign bus.reg_ack   = ack_q;
    assign bus.reg_rdata = rdata_q;
    assign cap_intr      = (done_q & cfg_q[5]) | (ovf_q & cfg_q[6]);

endmodule

// File: tb/tb_pwm_capture.sv
// Directed + randomized bench for pwm_capture with a waveform-level reference.
module tb_pwm_capture;

    localparam int unsigned W = 4;
`ifdef PWM_CAP_GLITCH_FILT_EN
    localparam logic [31:0] ST7 = 32'h80;
    localparam int          LAT = 5;
`else
    localparam logic [31:0] ST7 = 32'h00;
    localparam int          LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pad;
    logic       intr;

    int checks = 0;
    int errors = 0;

    // Pad generator controls: mode 0 = static level, 1 = periodic h/l
    int         gen_mode = 0;
    logic       gen_level = 1'b0;
    int         gen_h = 1, gen_l = 1, gen_ph = 0;
    logic [2:0] gen_sel = 3'd0;

    pwm_capture_if bus_if ();

    pwm_capture #(.CNT_W(W)) dut (
        .mclk    (clk),
        .h_reset (rst),
        .bus     (bus_if),
        .pad_gpio(pad),
        .cap_intr(intr)
    );

    always #5 clk = ~clk;

    initial begin
        logic [7:0] p;
        logic       lvl;
        pad = '0;
        forever begin
            @(posedge clk);
            #2;
            if (gen_mode == 1) begin
                lvl    = (gen_ph < gen_h);
                gen_ph = (gen_ph + 1 >= gen_h + gen_l) ? 0 : gen_ph + 1;
            end else begin
                lvl = gen_level;
            end
            p = 8'($urandom);
            p[gen_sel] = lvl;
            pad = p;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        bus_if.reg_cs    = 1'b1;
        bus_if.reg_wr    = 1'b1;
        bus_if.reg_addr  = a;
        bus_if.reg_wdata = d;
        bus_if.reg_be    = be;
        tick();
        bus_if.reg_cs = 1'b0;
        bus_if.reg_wr = 1'b0;
        tick();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_if.reg_cs   = 1'b1;
        bus_if.reg_wr   = 1'b0;
        bus_if.reg_addr = a;
        check("rd_rdata_before_ack", bus_if.reg_rdata, 32'h0);
        tick();
        check("rd_ack", {31'd0, bus_if.reg_ack}, 32'h1);
        d = bus_if.reg_rdata;
        bus_if.reg_cs = 1'b0;
        tick();
        check("rd_rdata_after_ack", bus_if.reg_rdata, 32'h0);
    endtask

    task automatic wait_intr(input string tag);
        int n;
        n = 0;
        while (!intr && n < 300) begin
            tick();
            n++;
        end
        check(tag, {31'd0, intr}, 32'h1);
    endtask

    task automatic poll_done(input string tag);
        logic [31:0] s;
        int n;
        s = '0;
        n = 0;
        while (s[0] !== 1'b1 && n < 100) begin
            bus_read(2'd1, s);
            n++;
        end
        check(tag, {31'd0, s[0]}, 32'h1);
    endtask

    task automatic set_wave(input logic [2:0] sel, input int h, input int l);
        gen_sel  = sel;
        gen_h    = h;
        gen_l    = l;
        gen_ph   = 0;
        gen_mode = 1;
    endtask

    task automatic set_level(input logic [2:0] sel, input logic v);
        gen_sel   = sel;
        gen_level = v;
        gen_mode  = 0;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] last_p, last_h;
        int          h, l, n;
        logic [2:0]  sel;
        logic        inv;

        rst              = 1'b1;
        bus_if.reg_cs    = 1'b0;
        bus_if.reg_wr    = 1'b0;
        bus_if.reg_addr  = 2'd0;
        bus_if.reg_wdata = '0;
        bus_if.reg_be    = 4'hF;
        repeat (3) tick();
        check("reset_intr", {31'd0, intr}, 32'h0);
        check("reset_ack", {31'd0, bus_if.reg_ack}, 32'h0);
        check("reset_rdata", bus_if.reg_rdata, 32'h0);
        rst = 1'b0;
        tick();
        bus_read(2'd0, d); check("reset_cfg", d, 32'h0);
        bus_read(2'd1, d); check("reset_status", d, ST7);
        bus_read(2'd2, d); check("reset_period", d, 32'h0);
        bus_read(2'd3, d); check("reset_high", d, 32'h0);

        // Byte enables
        bus_write(2'd0, 32'hFFFF_FFFF, 4'b0001);
        bus_read(2'd0, d); check("be_low_byte", d, 32'hFF);
        bus_write(2'd0, 32'h0, 4'b0001);
        bus_write(2'd0, 32'hFF, 4'b1110);
        bus_read(2'd0, d); check("be_masked", d, 32'h0);
        bus_write(2'd1, 32'h3, 4'b0001);

        // Continuous capture, 5 high / 3 low on gpio 0
        set_wave(3'd0, 5, 3);
        repeat (4) tick();
        bus_write(2'd0, 32'h21, 4'b0001);
        wait_intr("cont_intr");
        bus_if.reg_cs    = 1'b1;
        bus_if.reg_wr    = 1'b1;
        bus_if.reg_addr  = 2'd1;
        bus_if.reg_wdata = 32'h1;
        bus_if.reg_be    = 4'b0001;
        tick();
        check("w1c_intr_clear", {31'd0, intr}, 32'h0);
        bus_if.reg_cs = 1'b0;
        bus_if.reg_wr = 1'b0;
        tick();
        bus_read(2'd2, d); check("cont_period", d, 32'd8);
        bus_read(2'd3, d); check("cont_high", d, 32'd5);

        // Continuous mode overwrites with a new waveform
        set_wave(3'd0, 2, 4);
        repeat (20) tick();
        bus_write(2'd1, 32'h1, 4'b0001);
        wait_intr("cont2_intr_a");
        bus_write(2'd1, 32'h1, 4'b0001);
        wait_intr("cont2_intr_b");
        bus_read(2'd2, d); check("cont2_period", d, 32'd6);
        bus_read(2'd3, d); check("cont2_high", d, 32'd2);

        // One-shot with invert on gpio 1
        bus_write(2'd0, 32'h0, 4'b0001);
        bus_write(2'd1, 32'h3, 4'b0001);
        set_wave(3'd1, 4, 6);
        repeat (4) tick();
        bus_write(2'd0, 32'h93, 4'b0001);
        poll_done("os_done");
        bus_read(2'd3, d); check("os_high", d, 32'd6);
        bus_read(2'd2, d); check("os_period", d, 32'd10);
        bus_read(2'd1, d); check("os_status", d, ST7 | 32'h1);
        set_wave(3'd1, 2, 3);
        repeat (40) tick();
        bus_read(2'd2, d); check("os_hold_period", d, 32'd10);
        bus_read(2'd3, d); check("os_hold_high", d, 32'd6);
        bus_write(2'd1, 32'h1, 4'b0001);
        poll_done("os_rearm_done");
        bus_read(2'd2, d); check("os_rearm_period", d, 32'd5);
        bus_read(2'd3, d); check("os_rearm_high", d, 32'd3);

        // Randomized one-shot captures against the waveform model
        last_p = 32'd5;
        last_h = 32'd3;
        for (int t = 0; t < 6; t++) begin
            h   = $urandom_range(7, 2);
            l   = $urandom_range(7, 2);
            sel = 3'($urandom_range(7, 0));
            inv = 1'($urandom_range(1, 0));
            bus_write(2'd0, 32'h0, 4'b0001);
            bus_write(2'd1, 32'h3, 4'b0001);
            set_wave(sel, h, l);
            repeat (3) tick();
            bus_write(2'd0, 32'hA1 | (32'(inv) << 4) | (32'(sel) << 1), 4'b0001);
            wait_intr("rnd_intr");
            last_p = 32'(h + l);
            last_h = inv ? 32'(l) : 32'(h);
            bus_read(2'd2, d); check("rnd_period", d, last_p);
            bus_read(2'd3, d); check("rnd_high", d, last_h);
            bus_read(2'd1, d); check("rnd_status", d, ST7 | 32'h1);
        end

        // Overflow: rise then held high for the full counter range
        bus_write(2'd0, 32'h0, 4'b0001);
        bus_write(2'd1, 32'h3, 4'b0001);
        set_level(3'd2, 1'b0);
        bus_write(2'd0, 32'h45, 4'b0001);
        repeat (10) tick();
        gen_level = 1'b1;
        n = 0;
        while (!intr && n < 60) begin
            tick();
            n++;
        end
        check("ovf_latency", 32'(n), 32'(LAT + (1 << W) - 1));
        bus_read(2'd1, d); check("ovf_status", d, ST7 | 32'h6);
        bus_read(2'd2, d); check("ovf_period_kept", d, last_p);
        bus_read(2'd3, d); check("ovf_high_kept", d, last_h);
        bus_write(2'd1, 32'h2, 4'b0001);
        check("ovf_intr_clear", {31'd0, intr}, 32'h0);

        // Disable while measuring the low phase
        bus_write(2'd0, 32'h0, 4'b0001);
        bus_write(2'd1, 32'h3, 4'b0001);
        set_level(3'd3, 1'b0);
        bus_write(2'd0, 32'h07, 4'b0001);
        repeat (8) tick();
        gen_level = 1'b1;
        repeat (3) tick();
        gen_level = 1'b0;
        repeat (5) tick();
        bus_read(2'd1, d); check("dis_in_meas_low", d, ST7 | 32'hC);
        bus_write(2'd0, 32'h0, 4'b0001);
        bus_read(2'd1, d); check("dis_status_idle", d, ST7);
        bus_read(2'd2, d); check("dis_period_kept", d, last_p);
        bus_read(2'd3, d); check("dis_high_kept", d, last_h);

`ifdef PWM_CAP_GLITCH_FILT_EN
        // Single-cycle glitch must not start a measurement
        bus_write(2'd1, 32'h3, 4'b0001);
        set_level(3'd4, 1'b0);
        bus_write(2'd0, 32'h29, 4'b0001);
        repeat (8) tick();
        gen_level = 1'b1;
        tick();
        gen_level = 1'b0;
        repeat (30) tick();
        bus_read(2'd1, d); check("glitch_rejected", d, ST7 | 32'h4);
        bus_write(2'd0, 32'h0, 4'b0001);
`endif

        // Synchronous reset in the middle of a measurement
        set_wave(3'd0, 5, 3);
        bus_write(2'd1, 32'h3, 4'b0001);
        bus_write(2'd0, 32'h61, 4'b0001);
        wait_intr("rst_pre_intr");
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst_intr", {31'd0, intr}, 32'h0);
        check("rst_ack", {31'd0, bus_if.reg_ack}, 32'h0);
        check("rst_rdata", bus_if.reg_rdata, 32'h0);
        rst = 1'b0;
        bus_read(2'd0, d); check("rst_cfg", d, 32'h0);
        bus_read(2'd1, d); check("rst_status", d, ST7);
        bus_read(2'd2, d); check("rst_period", d, 32'h0);
        bus_read(2'd3, d); check("rst_high", d, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
